booth_op_sequencer: RTL and testbench
=====================================

BOOTH_OP_SEQUENCER -- requirements
Module: booth_op_sequencer

Interface
REQ-001 Parameter N, default 16: operand width; product width is 2N.
REQ-002 Parameter TIMEOUT, default 4*N+8: maximum cycles from start assertion to core_done before abort.
REQ-003 clk  in  1  sole clock; all state updates on the rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 in_valid  in  1  upstream operand pair valid.
REQ-006 in_ready  out  1  sequencer can accept an operand pair.
REQ-007 in_mcand  in  N  multiplicand, two's complement.
REQ-008 in_mplier  in  N  multiplier, two's complement.
REQ-009 data_bus  out  N  shared operand bus into the multiplier datapath.
REQ-010 start  out  1  start request to the multiplier controller.
REQ-011 core_ldM, core_ldQ  in  1 each  controller load strobes for the M and Q registers.
REQ-012 core_done  in  1  controller done flag.
REQ-013 core_a, core_q  in  N each  datapath A and Q registers.
REQ-014 core_restart  out  1  one-cycle pulse that re-arms the multiplier core.
REQ-015 out_valid  out  1  result valid; out_ready  in  1  downstream accepts.
REQ-016 out_product  out  2N  signed product {A,Q}; out_err  out  1  result aborted by timeout.

Function
REQ-017 States: IDLE, ARM, RUN, RESTART, OUT; the encoding is free.
REQ-018 IDLE: in_ready=1; on in_valid&in_ready, register both operands, clear the watchdog, and go to ARM.
REQ-019 in_ready SHALL be 0 in every state other than IDLE; there is no buffering beyond one operand pair.
REQ-020 ARM: start=1; on the first cycle core_ldM=1, go to RUN; start drops the cycle after ldM is seen.
REQ-021 data_bus = registered mplier when core_ldQ=1, otherwise registered mcand; the selection is combinational on core_ldQ.
REQ-022 RUN: wait for core_done=1; capture {core_a,core_q} into out_product in the same edge; out_err=0; go to RESTART.
REQ-023 RESTART: core_restart=1 for exactly one cycle, then go to OUT.
REQ-024 OUT: out_valid=1; out_product and out_err hold stable until out_valid&out_ready, then go to IDLE.
REQ-025 out_valid SHALL NOT deassert without a handshake.
REQ-026 Watchdog counts cycles in ARM and RUN; at count==TIMEOUT-1 without core_done: out_product=0, out_err=1, go to RESTART.
REQ-027 If core_done and the timeout coincide, core_done wins (out_err=0).
REQ-028 core_done seen in ARM before core_ldM is ignored.
REQ-029 Latency from the accept edge to out_valid = controller cycles + 2; out_valid may go high at the earliest 3 cycles after accept.

Reset
REQ-030 While rst_n=0: state=IDLE, start=0, core_restart=0, out_valid=0, out_err=0, out_product=0, operand registers=0, watchdog=0; in_ready=1.
REQ-031 Reset mid-operation discards the operation with no result emitted; the first cycle after release is IDLE.

Structure
REQ-032 The state encoding, a default-width constant, and the timeout formula SHALL live in the shared multiplier package.
REQ-033 One sub-module is natural: booth_watchdog (loadable up-counter with terminal flag); everything else stays flat.

Verification
REQ-034 mcand=7, mplier=5, model core done after 40 cycles with A=0x0000, Q=0x0023 -> out_product=0x00000023, out_err=0, core_restart pulsed once.
REQ-035 mcand=3, mplier=-2 (0xFFFE), core returns 0xFFFF/0xFFFA -> out_product=0xFFFFFFFA; data_bus=0xFFFE exactly while core_ldQ=1.
REQ-036 out_ready held 0 for 10 cycles after out_valid -> out_product stable, in_ready=0 throughout, IDLE one cycle after out_ready=1.
REQ-037 core_done never asserts -> after 72 cycles (N=16) out_valid=1, out_err=1, out_product=0.
REQ-038 rst_n pulsed low during RUN -> all outputs at reset values asynchronously, no out_valid afterwards, next operand accepted normally.
REQ-039 core_done on the same cycle the watchdog expires -> out_err=0, captured product emitted.

Source files
------------

// File: rtl/booth_op_sequencer_pkg.sv
// Shared definitions for the Booth multiplier operand sequencer: state encoding,
// default operand width and the watchdog timeout formula.
package booth_op_sequencer_pkg;

    localparam int BOOTH_N_DEFAULT = 16;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARM     = 3'd1,
        ST_RUN     = 3'd2,
        ST_RESTART = 3'd3,
        ST_OUT     = 3'd4
    } seq_state_t;

    // Worst-case controller run is about 4 cycles per operand bit plus setup.
    function automatic int booth_timeout(input int n);
        return 4 * n + 8;
    endfunction

endpackage

// File: rtl/booth_watchdog.sv
// Loadable up-counter that flags when it reaches LIMIT-1 and then holds there,
// so the terminal flag stays up until the next clear.
module booth_watchdog #(
    parameter int LIMIT = 72
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = $clog2(LIMIT + 1);

    logic [W-1:0] count;

    assign expired = (count == W'(LIMIT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/booth_op_sequencer.sv
// Hands one operand pair at a time to the Booth multiplier core, collects the
// {A,Q} product, and aborts with out_err when the core overruns the watchdog.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | waiting for an operand pair, in_ready high
// ST_ARM     | start asserted, waiting for the core to load M
// ST_RUN     | core multiplying, waiting for core_done or timeout
// ST_RESTART | one-cycle core_restart pulse to re-arm the core
// ST_OUT     | result presented, waiting for downstream handshake
module booth_op_sequencer
    import booth_op_sequencer_pkg::*;
#(
    parameter int N       = BOOTH_N_DEFAULT,
    parameter int TIMEOUT = booth_timeout(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   in_mcand,
    input  logic [N-1:0]   in_mplier,
    output logic [N-1:0]   data_bus,
    output logic           start,
    input  logic           core_ldM,
    input  logic           core_ldQ,
    input  logic           core_done,
    input  logic [N-1:0]   core_a,
    input  logic [N-1:0]   core_q,
    output logic           core_restart,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] out_product,
    output logic           out_err
);

    seq_state_t   state;
    seq_state_t   state_nxt;
    logic [N-1:0] mcand_r;
    logic [N-1:0] mplier_r;
    logic         accept;
    logic         capture;
    logic         abort;
    logic         wd_expired;

    assign accept = in_valid && in_ready;

    // The core samples Q from the bus during its ldQ strobe, M at all other times.
    assign data_bus = core_ldQ ? mplier_r : mcand_r;

    booth_watchdog #(
        .LIMIT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (accept),
        .enable  ((state == ST_ARM) || (state == ST_RUN)),
        .expired (wd_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        in_ready     = 1'b0;
        start        = 1'b0;
        core_restart = 1'b0;
        out_valid    = 1'b0;
        capture      = 1'b0;
        abort        = 1'b0;
        unique case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = ST_ARM;
                end
            end
            ST_ARM: begin
                start = 1'b1;
                // core_done is meaningless before M is loaded, so it is not looked at here.
                if (wd_expired) begin
                    abort     = 1'b1;
                    state_nxt = ST_RESTART;
                end else if (core_ldM) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (core_done) begin
                    capture   = 1'b1;
                    state_nxt = ST_RESTART;
                end else if (wd_expired) begin
                    abort     = 1'b1;
                    state_nxt = ST_RESTART;
                end
            end
            ST_RESTART: begin
                core_restart = 1'b1;
                state_nxt    = ST_OUT;
            end
            ST_OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_r     <= '0;
            mplier_r    <= '0;
            out_product <= '0;
            out_err     <= 1'b0;
        end else begin
            if (accept) begin
                mcand_r  <= in_mcand;
                mplier_r <= in_mplier;
            end
            if (capture) begin
                out_product <= {core_a, core_q};
                out_err     <= 1'b0;
            end else if (abort) begin
                out_product <= '0;
                out_err     <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_booth_op_sequencer.sv
// Self-checking bench for booth_op_sequencer: directed vector table, random
// transactions against a cycle-level reference model, and a mid-run reset.
module tb_booth_op_sequencer;

    localparam int N   = 16;
    localparam int TMO = 4 * N + 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [N-1:0]   in_mcand = '0;
    logic [N-1:0]   in_mplier = '0;
    logic [N-1:0]   data_bus;
    logic           start;
    logic           core_ldM = 1'b0;
    logic           core_ldQ = 1'b0;
    logic           core_done = 1'b0;
    logic [N-1:0]   core_a = '0;
    logic [N-1:0]   core_q = '0;
    logic           core_restart;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [2*N-1:0] out_product;
    logic           out_err;

    int    checks = 0;
    int    failures = 0;
    string cur_tag = "reset";

    always #5 clk = ~clk;

    booth_op_sequencer #(.N(N)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_mcand     (in_mcand),
        .in_mplier    (in_mplier),
        .data_bus     (data_bus),
        .start        (start),
        .core_ldM     (core_ldM),
        .core_ldQ     (core_ldQ),
        .core_done    (core_done),
        .core_a       (core_a),
        .core_q       (core_q),
        .core_restart (core_restart),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_product  (out_product),
        .out_err      (out_err)
    );

    typedef struct {
        logic [N-1:0]   mcand;
        logic [N-1:0]   mplier;
        int             ldm_dly;   // cycles in ARM before the core pulses ldM
        int             done_dly;  // cycles after the ldQ cycle until core_done
        bit             never;     // core never reports done
        bit             spurious;  // core_done held high while still in ARM
        int             ready_dly; // cycles out_ready stays low after out_valid
        logic [N-1:0]   a;
        logic [N-1:0]   q;
        logic [2*N-1:0] exp_prod;
        bit             exp_err;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s %s: actual=0x%0h required=0x%0h", cur_tag, name, act, exp);
        end
    endtask

    // Cycle (counted from the accept edge) on which the sequencer decides the
    // outcome, and whether that outcome is a timeout abort.
    function automatic void model(input vec_t v, output int r, output bit ab);
        int d;
        d = v.ldm_dly + 1 + v.done_dly;
        if (v.ldm_dly >= TMO - 1) begin
            r  = TMO - 1;
            ab = 1'b1;
        end else if (!v.never && d <= TMO - 1) begin
            r  = d;
            ab = 1'b0;
        end else begin
            r  = TMO - 1;
            ab = 1'b1;
        end
    endfunction

    task automatic run_vec(input vec_t v);
        int r;
        bit ab;
        int c;
        bit hs;
        model(v, r, ab);
        @(negedge clk);
        in_valid  = 1'b1;
        in_mcand  = v.mcand;
        in_mplier = v.mplier;
        out_ready = 1'b0;
        #1;
        chk("in_ready_idle", 64'(in_ready), 64'(1));
        @(negedge clk);
        in_valid  = 1'b0;
        in_mcand  = N'($urandom);
        in_mplier = N'($urandom);
        c  = 0;
        hs = 1'b0;
        while (!hs && c < 400) begin
            core_ldM  = (c == v.ldm_dly);
            core_ldQ  = (c == v.ldm_dly + 1);
            core_done = v.spurious && (c < v.ldm_dly);
            core_a    = N'($urandom);
            core_q    = N'($urandom);
            if (!v.never && c == v.ldm_dly + 1 + v.done_dly) begin
                core_done = 1'b1;
                core_a    = v.a;
                core_q    = v.q;
            end
            out_ready = (c >= r + 2 + v.ready_dly);
            #1;
            chk("in_ready_busy", 64'(in_ready), 64'(0));
            chk("start", 64'(start), 64'(c <= v.ldm_dly && c <= r));
            chk("core_restart", 64'(core_restart), 64'(c == r + 1));
            chk("out_valid", 64'(out_valid), 64'(c >= r + 2));
            chk("data_bus", 64'(data_bus), 64'(core_ldQ ? v.mplier : v.mcand));
            if (c >= r + 2) begin
                chk("out_product", 64'(out_product), 64'(v.exp_prod));
                chk("out_err", 64'(out_err), 64'(v.exp_err));
            end
            if (out_valid && out_ready) hs = 1'b1;
            @(negedge clk);
            c++;
        end
        core_ldM  = 1'b0;
        core_ldQ  = 1'b0;
        core_done = 1'b0;
        out_ready = 1'b0;
        if (!hs) begin
            chk("handshake_bound", 64'(0), 64'(1));
        end else begin
            #1;
            chk("idle_after_hs", 64'(in_ready), 64'(1));
            chk("valid_after_hs", 64'(out_valid), 64'(0));
        end
    endtask

    function automatic vec_t mk(input logic [N-1:0] mc, input logic [N-1:0] mp,
                                input int ldm, input int dd, input bit nv, input bit sp,
                                input int rd, input logic [N-1:0] a, input logic [N-1:0] q,
                                input logic [2*N-1:0] ep, input bit ee);
        vec_t v;
        v.mcand = mc; v.mplier = mp; v.ldm_dly = ldm; v.done_dly = dd; v.never = nv;
        v.spurious = sp; v.ready_dly = rd; v.a = a; v.q = q; v.exp_prod = ep; v.exp_err = ee;
        return v;
    endfunction

    vec_t table_v[9];

    initial begin
        table_v[0] = mk(16'd7, 16'd5, 0, 39, 1'b0, 1'b0, 0, 16'h0000, 16'h0023, 32'h00000023, 1'b0);
        table_v[1] = mk(16'd3, 16'hFFFE, 2, 5, 1'b0, 1'b1, 0, 16'hFFFF, 16'hFFFA, 32'hFFFFFFFA, 1'b0);
        table_v[2] = mk(16'hFFFC, 16'd9, 1, 10, 1'b0, 1'b0, 10, 16'hFFFF, 16'hFFDC, 32'hFFFFFFDC, 1'b0);
        table_v[3] = mk(16'd11, 16'd13, 0, 0, 1'b1, 1'b0, 0, 16'h0000, 16'h0000, 32'h00000000, 1'b1);
        table_v[4] = mk(16'h0102, 16'h0304, 0, 70, 1'b0, 1'b0, 1, 16'h1234, 16'h5678, 32'h12345678, 1'b0);
        table_v[5] = mk(16'h0102, 16'h0304, 0, 71, 1'b0, 1'b0, 0, 16'h1234, 16'h5678, 32'h00000000, 1'b1);
        table_v[6] = mk(16'd2, 16'd2, 0, 0, 1'b0, 1'b0, 0, 16'h0000, 16'h0004, 32'h00000004, 1'b0);
        table_v[7] = mk(16'd5, 16'd6, 200, 0, 1'b0, 1'b1, 2, 16'h0000, 16'h001E, 32'h00000000, 1'b1);
        table_v[8] = mk(16'h8000, 16'h8000, 3, 20, 1'b0, 1'b1, 4, 16'h4000, 16'h0000, 32'h40000000, 1'b0);

        #3;
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        chk("rst_start", 64'(start), 64'(0));
        chk("rst_core_restart", 64'(core_restart), 64'(0));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_err", 64'(out_err), 64'(0));
        chk("rst_out_product", 64'(out_product), 64'(0));
        chk("rst_data_bus", 64'(data_bus), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            cur_tag = $sformatf("vec%0d", i);
            run_vec(table_v[i]);
        end

        for (int i = 0; i < 24; i++) begin
            vec_t        v;
            int          r;
            bit          ab;
            int          pm;
            logic [31:0] pp;
            v.mcand     = N'($urandom);
            v.mplier    = N'($urandom);
            v.ldm_dly   = int'($urandom_range(0, 3));
            v.done_dly  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(60, 75))
                                                      : int'($urandom_range(0, 40));
            v.never     = ($urandom_range(0, 9) == 0);
            v.spurious  = 1'($urandom);
            v.ready_dly = int'($urandom_range(0, 3));
            pm          = int'($signed(v.mcand)) * int'($signed(v.mplier));
            pp          = 32'(pm);
            v.a         = pp[31:16];
            v.q         = pp[15:0];
            model(v, r, ab);
            v.exp_prod  = ab ? '0 : pp;
            v.exp_err   = ab;
            cur_tag     = $sformatf("rnd%0d", i);
            run_vec(v);
        end

        cur_tag = "midreset";
        @(negedge clk);
        in_valid  = 1'b1;
        in_mcand  = 16'd9;
        in_mplier = 16'd9;
        @(negedge clk);
        in_valid = 1'b0;
        core_ldM = 1'b1;
        @(negedge clk);
        core_ldM = 1'b0;
        core_ldQ = 1'b1;
        @(negedge clk);
        core_ldQ = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_in_ready", 64'(in_ready), 64'(1));
        chk("async_start", 64'(start), 64'(0));
        chk("async_core_restart", 64'(core_restart), 64'(0));
        chk("async_out_valid", 64'(out_valid), 64'(0));
        chk("async_out_err", 64'(out_err), 64'(0));
        chk("async_out_product", 64'(out_product), 64'(0));
        chk("async_data_bus", 64'(data_bus), 64'(0));
        @(negedge clk);
        rst_n     = 1'b1;
        core_done = 1'b1;
        core_a    = 16'h0000;
        core_q    = 16'h0051;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk("post_rst_out_valid", 64'(out_valid), 64'(0));
            chk("post_rst_restart", 64'(core_restart), 64'(0));
            chk("post_rst_in_ready", 64'(in_ready), 64'(1));
            @(negedge clk);
            core_done = 1'b0;
        end
        cur_tag = "after_reset";
        run_vec(mk(16'd9, 16'd9, 0, 30, 1'b0, 1'b0, 1, 16'h0000, 16'h0051, 32'h00000051, 1'b0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
